regfile_port_arbiter: RTL
=========================

# regfile_port_arbiter

Sequencer and arbiter for the shared register-file address port, the port fed through the write/check selection mux. Two requesters share it. The instruction decoder issues register writes. The print module requests a full sweep of the register bank to compare register contents. Writes always win; the sweep pauses and resumes without skipping or repeating a register.

## Interface
Parameters:
- NUM_REGS, 32, number of registers swept (1..32)
- ADDR_W, 5, register address width

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
- wr_req  in  1  decoder write request; held until wr_ack
- wr_reg  in  ADDR_W  decoder target register; stable while wr_req high
- wr_ack  out  1  one-cycle grant pulse for the pending write
- scan_start  in  1  print module sweep request (pulse or level; sampled in IDLE only)
- scan_busy  out  1  high from sweep acceptance until scan_done cycle inclusive
- scan_valid  out  1  register-file read data corresponds to scan_reg this cycle
- scan_reg  out  ADDR_W  register whose data is presented with scan_valid
- scan_done  out  1  one-cycle pulse coincident with the last scan_valid
- selector  out  1  mux select: 1 = decoder write_R path, 0 = print check_R path
- reg_addr  out  ADDR_W  register number driven toward the mux/register file
- rf_we  out  1  register-file write enable

## Operation
- All outputs are registered. Reset value of every output is 0; FSM goes to IDLE; sweep index goes to 0.
- FSM states:
  - IDLE: scan_start=1 moves to SCAN with index=0.
  - SCAN: issues one read per non-write cycle; after index NUM_REGS-1 is issued, moves to DRAIN.
  - DRAIN: waits one cycle for the final read data, asserts scan_done, returns to IDLE.
- Write grant: a grant is issued in cycle t when wr_req=1 at edge t-1 and wr_ack=0 at edge t-1. In the grant cycle, selector=1, reg_addr=wr_reg, rf_we=1 and wr_ack=1, all for exactly one cycle. Grants are legal in every FSM state.
- Back-to-back rule: no grant is issued in the cycle after an ack. At most one write per 2 cycles, so there is no double grant while the requester drops wr_req.
- Sweep issue: in SCAN, any cycle without a write grant drives selector=0, reg_addr=index, rf_we=0, and increments index. In a grant cycle the index holds.
- Read latency is 1 cycle. Address issued at cycle t gives scan_valid=1 and scan_reg=that address at t+1. There is no scan_valid after a write-grant cycle.
- Non-issuing cycles (IDLE, DRAIN, or after a grant): selector=0, reg_addr=0, rf_we=0.
- scan_start while scan_busy: ignored, not queued.
- A write to an already-swept register is not re-swept. A write to a not-yet-swept register is seen by the sweep with the new value.
- Index arithmetic is ADDR_W bits. The terminal compare is against NUM_REGS-1, so there is no wrap for NUM_REGS=32.
- reset mid-sweep or mid-grant aborts immediately. No scan_done is produced and the next cycle is IDLE with all outputs 0.

## Timing
- Write latency: wr_req rising at edge t gives wr_ack, rf_we and selector=1 during cycle t+1.
- Uncontended sweep latency: scan_start at edge t gives the first scan_valid at cycle t+2 and scan_done at cycle t+NUM_REGS+1.
- Each write grant during a sweep adds exactly 1 cycle to the sweep.
- scan_busy rises at cycle t+1 and falls after the scan_done cycle.
- scan_reg sequence is strictly 0,1,..,NUM_REGS-1 with no gaps or repeats, regardless of writes.

## Structure
- A shared header (`include`) holds the FSM state encodings (IDLE, SCAN, DRAIN) and the default NUM_REGS/ADDR_W values used by the register file and print module.
- One natural sub-module: regfile_scan_counter. It holds the index register, exposes enable/clear inputs and a terminal flag, and has its own parameter NUM_REGS.
- The top level holds the FSM, the grant logic and the output registers.

## Test plan
- Reset with all inputs 0: every output is 0 for 3 cycles. wr_req=1, wr_reg=7: cycle+1 shows selector=1, reg_addr=7, rf_we=1, wr_ack=1. The pulse lasts one cycle only.
- Uncontended sweep, NUM_REGS=32: scan_start pulse gives scan_reg 0..31 on 32 consecutive scan_valid cycles, with scan_done on reg 31. scan_busy spans 33 cycles.
- Write mid-sweep: wr_req (reg 5) held while the index is 10. Expect one grant cycle, one scan_valid bubble, and a sweep resuming at 10. scan_done is 1 cycle later than uncontended.
- wr_req held high for 6 cycles: grants land on alternate cycles only, 3 acks total. The sweep interleaves in the gaps and shows no repeated scan_reg.
- scan_start pulsed during a sweep is ignored; exactly one scan_done occurs. A scan_start on the cycle after scan_done starts a new sweep at 0.
- reset asserted at index 12 (with a concurrent write grant): the next cycle has all outputs 0, state is IDLE and no scan_done occurs. A fresh scan_start restarts from 0.

Source files
------------

// File: rtl/regfile_port_arbiter_pkg.sv
// Shared definitions for the register-file port arbiter: sweep FSM state
// encodings and the default register-bank geometry used by the register
// file and the print module.
package regfile_port_arbiter_pkg;

    localparam int DEFAULT_NUM_REGS = 32;
    localparam int DEFAULT_ADDR_W   = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2
    } arbState_t;

endpackage

// File: rtl/regfile_scan_counter.sv
// Sweep index for the register-bank scan. Counts up by one on each issued
// read, can be cleared back to register 0, and flags when the index sits on
// the last register of the bank.
module regfile_scan_counter
    import regfile_port_arbiter_pkg::*;
#(
    parameter int NUM_REGS = DEFAULT_NUM_REGS,
    parameter int ADDR_W   = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_enable,
    input  logic              i_clear,
    output logic [ADDR_W-1:0] o_index,
    output logic              o_terminal
);

    localparam logic [ADDR_W-1:0] LAST_INDEX = ADDR_W'(NUM_REGS - 1);

    logic [ADDR_W-1:0] r_index;

    // Index register: clear has priority so a terminal issue returns to 0
    // instead of stepping past the last register.
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_index <= '0;
        end else if (i_enable) begin
            r_index <= r_index + ADDR_W'(1);
        end
    end

    assign o_index    = r_index;
    assign o_terminal = (r_index == LAST_INDEX);

endmodule

// File: rtl/regfile_port_arbiter.sv
// Arbiter and sequencer for the shared register-file address port. Decoder
// writes always win the port; the print module's full-bank sweep fills every
// cycle that is not a write grant and pauses in place while a write is granted,
// so the swept register sequence never skips or repeats.
module regfile_port_arbiter
    import regfile_port_arbiter_pkg::*;
#(
    parameter int NUM_REGS = DEFAULT_NUM_REGS,
    parameter int ADDR_W   = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_reg,
    output logic              wr_ack,
    input  logic              scan_start,
    output logic              scan_busy,
    output logic              scan_valid,
    output logic [ADDR_W-1:0] scan_reg,
    output logic              scan_done,
    output logic              selector,
    output logic [ADDR_W-1:0] reg_addr,
    output logic              rf_we
);

    arbState_t         r_state;
    arbState_t         w_stateNext;

    logic              r_wrAck;
    logic              r_selector;
    logic              r_rfWe;
    logic [ADDR_W-1:0] r_regAddr;
    logic              r_issued;
    logic              r_scanValid;
    logic [ADDR_W-1:0] r_scanReg;
    logic              r_scanDone;
    logic              r_scanBusy;

    logic              w_grant;
    logic              w_sweepActive;
    logic              w_issue;
    logic              w_lastIssue;
    logic              w_counterClear;
    logic [ADDR_W-1:0] w_index;
    logic              w_terminal;

    // A write is granted for the next cycle unless one is being acked right
    // now, which spaces grants at least two cycles apart and keeps a
    // requester that is still dropping wr_req from getting a second grant.
    assign w_grant = wr_req && !r_wrAck;

    // The counter rests at 0 in IDLE and is returned there after the last
    // register is issued, so a new sweep always begins at register 0.
    assign w_counterClear = w_lastIssue || ((r_state == ST_IDLE) && !w_issue);

    regfile_scan_counter #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_scanCounter (
        .clk        (clk),
        .reset      (reset),
        .i_enable   (w_issue),
        .i_clear    (w_counterClear),
        .o_index    (w_index),
        .o_terminal (w_terminal)
    );

    // Sweep FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state logic: decides whether the coming cycle carries a sweep read
    // and moves to DRAIN once the last register's read has been issued.
    always_comb begin
        w_stateNext   = r_state;
        w_sweepActive = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (scan_start && !r_scanBusy) begin
                    w_sweepActive = 1'b1;
                    w_stateNext   = ST_SCAN;
                end
            end
            ST_SCAN: begin
                w_sweepActive = 1'b1;
            end
            ST_DRAIN: begin
                w_stateNext = ST_IDLE;
            end
            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase
        w_issue     = w_sweepActive && !w_grant;
        w_lastIssue = w_issue && w_terminal;
        if (w_lastIssue) begin
            w_stateNext = ST_DRAIN;
        end
    end

    // Output registers: port drive for the coming cycle, then the read-data
    // qualifiers one cycle behind the issued address.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wrAck     <= 1'b0;
            r_selector  <= 1'b0;
            r_rfWe      <= 1'b0;
            r_regAddr   <= '0;
            r_issued    <= 1'b0;
            r_scanValid <= 1'b0;
            r_scanReg   <= '0;
            r_scanDone  <= 1'b0;
            r_scanBusy  <= 1'b0;
        end else begin
            r_wrAck     <= w_grant;
            r_selector  <= w_grant;
            r_rfWe      <= w_grant;
            r_regAddr   <= w_grant ? wr_reg : (w_issue ? w_index : '0);
            r_issued    <= w_issue;
            r_scanValid <= r_issued;
            r_scanReg   <= r_issued ? r_regAddr : '0;
            r_scanDone  <= r_issued && (r_state == ST_DRAIN);
            r_scanBusy  <= (w_stateNext != ST_IDLE) || (r_state == ST_DRAIN);
        end
    end

    assign wr_ack     = r_wrAck;
    assign selector   = r_selector;
    assign rf_we      = r_rfWe;
    assign reg_addr   = r_regAddr;
    assign scan_valid = r_scanValid;
    assign scan_reg   = r_scanReg;
    assign scan_done  = r_scanDone;
    assign scan_busy  = r_scanBusy;

endmodule
